rr_arb16: RTL and testbench
===========================

Name: rr_arb16

Overview:
- 16-requester round-robin arbiter with grant lock and a hold timeout.
- Shares one downstream resource among requesters 0..15.
- Reuses the 16-input priority-encoder convention: a valid flag plus a 4-bit index, where the highest index wins within the current search window.
- Sits ahead of any shared datapath unit (bus port, ALU, memory port) that needs one owner per cycle.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant while others wait. 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  16  request vector; bit i = requester i wants the resource; level-sensitive
- gnt_valid  output  1  a grant is active this cycle
- gnt_idx  output  4  binary index of the granted requester; 0 when gnt_valid=0
- gnt_oh  output  16  one-hot grant; exactly bit gnt_idx set when gnt_valid=1, else 0

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: state changes only on the rising edge of clk, and rst sampled high at that edge resets the block.
- Reset values:
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0
  - rotation pointer ptr=15
  - hold counter hcnt=0
  - rst has priority over all other inputs.
- All outputs are registered. There is no combinational path from req to any output.
- Search function pick(mask, ptr):
  - Scan indices ptr, ptr-1, ..., 0, 15, ..., ptr+1 (descending, wrap from 0 to 15).
  - Return the first set bit of mask and found=1.
  - found=0 if mask==0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0: next edge enters GRANT with gnt_idx=pick(req,ptr), gnt_valid=1, hcnt=0.
  - Otherwise remain in IDLE.
  - Latency from req rising to gnt_valid is 1 cycle.
- GRANT, with k=gnt_idx:
  - Release (req[k]==0 sampled):
    - If pick(req,(k-1) mod 16) finds j: next edge grants j with no bubble cycle, ptr=(k-1) mod 16, hcnt=0.
    - Else: next edge goes to IDLE, gnt_valid=0, gnt_idx=0, gnt_oh=0, ptr=(k-1) mod 16.
  - Timeout (MAX_HOLD!=0, req[k]==1, hcnt==MAX_HOLD-1):
    - Let m = req with bit k cleared.
    - If pick(m,(k-1) mod 16) finds j: grant moves to j next edge, ptr=(k-1) mod 16, hcnt=0.
    - If m==0: k keeps the grant, hcnt=0, ptr unchanged.
  - Otherwise: hold k, hcnt=hcnt+1. hcnt saturates at MAX_HOLD-1 when MAX_HOLD!=0 and is frozen at 0 when MAX_HOLD=0.
- ptr changes only when the grant leaves a requester. After owner k is done, the search starts just below k, so every active requester is served within 16 grant turns (no starvation).
- Simultaneous release of k and assertion of new requests: the new requests are eligible in the same arbitration.
- Requests arriving or dropping on non-owner bits never disturb the current grant.
- Reset mid-grant: the next edge forces all reset values, even if req is held. Arbitration restarts from ptr=15 on the following cycle.
- Invariants:
  - gnt_oh == (gnt_valid ? 1<<gnt_idx : 0)
  - gnt_valid implies the owner's req bit was set on the previous edge
  - hcnt width is 16 bits

Test Plan:
- Reset then req=16'h2020 held:
  - gnt_valid=1, gnt_idx=13 (1101), gnt_oh=16'h2000 one cycle after req.
  - Drop bit 13 (req=16'h0020): gnt_idx=5 on the next edge with no gap.
  - Drop to req=0: gnt_valid=0, gnt_idx=0 next edge.
- Rotation with MAX_HOLD=0:
  - req=16'h8001, owner 15 releases (req=16'h0001) then re-requests (req=16'h8001) while 0 is the owner.
  - After 0 releases, 15 is granted, because ptr=15 after 0 leaves.
  - Verify grant order 15, 0, 15.
- Timeout with MAX_HOLD=4, req=16'hFFFF held:
  - Grant 15 for exactly 4 cycles, then 14 for 4, then 13.
  - Every 4-cycle window has one owner; gnt_valid never drops.
- Timeout with single requester, MAX_HOLD=4, req=16'h0200:
  - gnt_idx=9 (1001) continuously for 20 cycles.
  - hcnt restarts every 4 cycles; no deassert glitch.
- Reset mid-operation:
  - Owner 7, req=16'h0081, assert rst for 1 cycle: outputs all 0 at that edge.
  - Next cycle gnt_idx=7 (search from ptr=15).
- Idle boundary:
  - req=0 for 10 cycles: gnt_valid=0, gnt_oh=0 throughout.
  - A single-cycle req=16'h0001 pulse gives gnt_idx=0, gnt_valid=1 for one cycle, then a release to IDLE.

Source files
------------

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with per-owner hold timeout.
// Outputs come from registered state only; a new request is granted one cycle after it is sampled.
module rr_arb16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt_oh
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [15:0] HOLD_LAST  = (MAX_HOLD == 0) ? 16'd0 : 16'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx_q, idx_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [15:0] hcnt, hcnt_nxt;
  logic [3:0]  km1;
  logic [4:0]  p_idle, p_rel, p_to;

  // Descending scan from start with wrap; the farthest hit is overwritten by nearer ones.
  function automatic logic [4:0] pick(input logic [15:0] mask, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = start - 4'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= 4'd0;
      ptr   <= 4'hF;
      hcnt  <= 16'd0;
    end else begin
      state <= state_nxt;
      idx_q <= idx_nxt;
      ptr   <= ptr_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    ptr_nxt   = ptr;
    hcnt_nxt  = hcnt;
    km1       = idx_q - 4'd1;
    p_idle    = pick(req, ptr);
    p_rel     = pick(req, km1);
    p_to      = pick(req & ~(16'd1 << idx_q), km1);
    case (state)
      IDLE: begin
        if (p_idle[4]) begin
          state_nxt = GRANT;
          idx_nxt   = p_idle[3:0];
          hcnt_nxt  = 16'd0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          ptr_nxt  = km1;
          hcnt_nxt = 16'd0;
          if (p_rel[4]) begin
            idx_nxt = p_rel[3:0];
          end else begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
          end
        end else if (TIMEOUT_EN && hcnt == HOLD_LAST) begin
          // With nobody else waiting the owner keeps the grant and its window restarts.
          hcnt_nxt = 16'd0;
          if (p_to[4]) begin
            idx_nxt = p_to[3:0];
            ptr_nxt = km1;
          end
        end else if (TIMEOUT_EN) begin
          hcnt_nxt = hcnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_valid = (state == GRANT);
    gnt_idx   = gnt_valid ? idx_q : 4'd0;
    gnt_oh    = gnt_valid ? (16'd1 << idx_q) : 16'd0;
  end

endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: one instance with MAX_HOLD=0 and one with MAX_HOLD=4 share the same stimulus.
module tb_rr_arb16;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        v0;
    logic [3:0]  i0;
    logic        v4;
    logic [3:0]  i4;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        gv0, gv4;
  logic [3:0]  gi0, gi4;
  logic [15:0] go0, go4;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_pass;
  int   n_tot;

  rr_arb16 #(.MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt_valid(gv0), .gnt_idx(gi0), .gnt_oh(go0)
  );

  rr_arb16 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req),
    .gnt_valid(gv4), .gnt_idx(gi4), .gnt_oh(go4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tv(input logic r, input logic [15:0] q, input logic v0, input logic [3:0] i0,
                    input logic v4, input logic [3:0] i4);
    vec_t v;
    v.rst = r; v.req = q; v.v0 = v0; v.i0 = i0; v.v4 = v4; v.i4 = i4;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step_no, input logic [15:0] act, input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
  endtask

  // Drive one vector, push its expectation, then compare after the edge that samples it.
  task automatic step(input vec_t v, input int step_no);
    vec_t e;
    logic [15:0] oh0, oh4;
    @(negedge clk);
    rst = v.rst;
    req = v.req;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", step_no);
    end else begin
      e   = sb.pop_front();
      oh0 = e.v0 ? (16'd1 << e.i0) : 16'd0;
      oh4 = e.v4 ? (16'd1 << e.i4) : 16'd0;
      chk("h0_valid", step_no, {15'd0, gv0}, {15'd0, e.v0});
      chk("h0_idx",   step_no, {12'd0, gi0}, {12'd0, (e.v0 ? e.i0 : 4'd0)});
      chk("h0_oh",    step_no, go0, oh0);
      chk("h4_valid", step_no, {15'd0, gv4}, {15'd0, e.v4});
      chk("h4_idx",   step_no, {12'd0, gi4}, {12'd0, (e.v4 ? e.i4 : 4'd0)});
      chk("h4_oh",    step_no, go4, oh4);
    end
  endtask

  task automatic hs(input logic r, input logic [15:0] q, input logic v0, input logic [3:0] i0,
                    input logic v4, input logic [3:0] i4, input int step_no);
    vec_t v;
    v.rst = r; v.req = q; v.v0 = v0; v.i0 = i0; v.v4 = v4; v.i4 = i4;
    step(v, step_no);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    rst    = 1'b1;
    req    = 16'h0;

    // Basic grant, no-gap handoff, release to idle.
    tv(1, 16'h0000, 0, 0,  0, 0);
    tv(0, 16'h2020, 1, 13, 1, 13);
    tv(0, 16'h0020, 1, 5,  1, 5);
    tv(0, 16'h0000, 0, 0,  0, 0);
    tv(0, 16'h0000, 0, 0,  0, 0);
    // Rotation 15 -> 0 -> 15, then a hold that only the MAX_HOLD=4 copy times out.
    tv(1, 16'h0000, 0, 0,  0, 0);
    tv(0, 16'h8001, 1, 15, 1, 15);
    tv(0, 16'h0001, 1, 0,  1, 0);
    tv(0, 16'h8001, 1, 0,  1, 0);
    tv(0, 16'h8000, 1, 15, 1, 15);
    tv(0, 16'h0000, 0, 0,  0, 0);
    for (int i = 0; i < 4; i++) tv(0, 16'h8001, 1, 0, 1, 0);
    tv(0, 16'h8001, 1, 0,  1, 15);
    tv(0, 16'h0000, 0, 0,  0, 0);
    // All requesting: 4-cycle windows on the timeout copy.
    tv(1, 16'h0000, 0, 0,  0, 0);
    for (int i = 0; i < 4; i++) tv(0, 16'hFFFF, 1, 15, 1, 15);
    for (int i = 0; i < 4; i++) tv(0, 16'hFFFF, 1, 15, 1, 14);
    tv(0, 16'hFFFF, 1, 15, 1, 13);
    tv(0, 16'h0000, 0, 0,  0, 0);
    // Lone requester keeps the grant across timeouts.
    tv(1, 16'h0000, 0, 0,  0, 0);
    for (int i = 0; i < 20; i++) tv(0, 16'h0200, 1, 9, 1, 9);
    tv(0, 16'h0000, 0, 0,  0, 0);
    // Reset mid-grant, then release while new requests appear.
    tv(1, 16'h0000, 0, 0,  0, 0);
    tv(0, 16'h0081, 1, 7,  1, 7);
    tv(0, 16'h0081, 1, 7,  1, 7);
    tv(1, 16'h0081, 0, 0,  0, 0);
    tv(0, 16'h0081, 1, 7,  1, 7);
    tv(0, 16'h0080, 1, 7,  1, 7);
    tv(0, 16'h0201, 1, 0,  1, 0);
    tv(0, 16'h0200, 1, 9,  1, 9);
    tv(0, 16'h0000, 0, 0,  0, 0);

    foreach (vecs[i]) step(vecs[i], i);

    // Idle boundary and a single-cycle pulse.
    for (int i = 0; i < 10; i++) hs(0, 16'h0000, 0, 0, 0, 0, 1000 + i);
    hs(0, 16'h0001, 1, 0, 1, 0, 1010);
    hs(0, 16'h0000, 0, 0, 0, 0, 1011);

    // Full rotation under timeout: owner steps down every 4 cycles and wraps to 15.
    hs(1, 16'h0000, 0, 0, 0, 0, 2000);
    for (int n = 0; n < 68; n++)
      hs(0, 16'hFFFF, 1, 15, 1, 4'(15 - (n / 4) % 16), 2001 + n);
    hs(0, 16'h0000, 0, 0, 0, 0, 2100);

    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
